// File: rtl/wb_writeback_unit.sv
// Writeback stage: selects the result source, extends/aligns load data and drives the register-file write port.
// Holds off execute (ex_ready_out=0) while a data-memory read is outstanding, aborting after LOAD_TIMEOUT cycles.
module wb_writeback_unit #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned LOAD_TIMEOUT = 16
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            ex_valid_in,
  output logic            ex_ready_out,
  input  logic            wb_en_in,
  input  logic [1:0]      wb_sel_in,
  input  logic [4:0]      rd_addr_in,
  input  logic [XLEN-1:0] alu_res_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] imm_in,
  input  logic [2:0]      funct3_in,
  input  logic            dmem_rvalid_in,
  input  logic [XLEN-1:0] dmem_rdata_in,
  output logic [4:0]      rd_addr_out,
  output logic [XLEN-1:0] rd_data_out,
  output logic            wr_en_out,
  output logic            retire_out,
  output logic [1:0]      err_out
);

  localparam int unsigned TW = $clog2(LOAD_TIMEOUT + 1);

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_PC4  = 2'b10;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_MISALGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL = 2'b11;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {S_IDLE, S_WAIT_LD} state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [4:0]      ld_rd_q, ld_rd_d;
  logic [2:0]      ld_f3_q, ld_f3_d;
  logic [1:0]      ld_off_q, ld_off_d;
  logic            ld_wben_q, ld_wben_d;
  logic            ready_q, ready_d;
  logic            wr_en_q, wr_en_d;
  logic            retire_q, retire_d;
  logic [1:0]      err_q, err_d;
  logic [4:0]      rd_addr_q, rd_addr_d;
  logic [XLEN-1:0] rd_data_q, rd_data_d;

  logic            accept;
  logic [1:0]      ld_chk_err;
  logic [XLEN-1:0] nonload_res;
  logic [XLEN-1:0] ld_word_sh;
  logic [XLEN-1:0] ld_half_sh;
  logic [XLEN-1:0] ld_ext;

  assign accept = ex_valid_in && ready_q;

  // Early load screening: illegal encodings and misaligned addresses never wait on memory.
  always_comb begin
    ld_chk_err = ERR_NONE;
    unique case (funct3_in)
      F3_LB, F3_LBU: ld_chk_err = ERR_NONE;
      F3_LH, F3_LHU: ld_chk_err = alu_res_in[0] ? ERR_MISALGN : ERR_NONE;
      F3_LW:         ld_chk_err = (alu_res_in[1:0] != 2'b00) ? ERR_MISALGN : ERR_NONE;
      default:       ld_chk_err = ERR_ILLEGAL;
    endcase
  end

  always_comb begin
    nonload_res = imm_in;
    if (wb_sel_in == SEL_ALU)      nonload_res = alu_res_in;
    else if (wb_sel_in == SEL_PC4) nonload_res = pc_in + XLEN'(4);
  end

  // Byte/half lane extraction from the aligned word, then sign/zero extension.
  always_comb begin
    ld_word_sh = dmem_rdata_in >> {ld_off_q, 3'b000};
    ld_half_sh = dmem_rdata_in >> {ld_off_q[1], 4'b0000};
    ld_ext     = dmem_rdata_in;
    unique case (ld_f3_q)
      F3_LB:   ld_ext = {{(XLEN-8){ld_word_sh[7]}}, ld_word_sh[7:0]};
      F3_LBU:  ld_ext = {{(XLEN-8){1'b0}}, ld_word_sh[7:0]};
      F3_LH:   ld_ext = {{(XLEN-16){ld_half_sh[15]}}, ld_half_sh[15:0]};
      F3_LHU:  ld_ext = {{(XLEN-16){1'b0}}, ld_half_sh[15:0]};
      default: ld_ext = dmem_rdata_in;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    ld_rd_d   = ld_rd_q;
    ld_f3_d   = ld_f3_q;
    ld_off_d  = ld_off_q;
    ld_wben_d = ld_wben_q;
    ready_d   = ready_q;
    wr_en_d   = 1'b0;
    retire_d  = 1'b0;
    err_d     = ERR_NONE;
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    unique case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (accept) begin
          if (wb_sel_in != SEL_LOAD) begin
            rd_addr_d = rd_addr_in;
            rd_data_d = nonload_res;
            retire_d  = 1'b1;
            wr_en_d   = wb_en_in && (rd_addr_in != 5'd0);
          end else if (ld_chk_err != ERR_NONE) begin
            rd_addr_d = rd_addr_in;
            rd_data_d = '0;
            retire_d  = 1'b1;
            err_d     = ld_chk_err;
          end else begin
            state_d   = S_WAIT_LD;
            ready_d   = 1'b0;
            timer_d   = '0;
            ld_rd_d   = rd_addr_in;
            ld_f3_d   = funct3_in;
            ld_off_d  = alu_res_in[1:0];
            ld_wben_d = wb_en_in;
          end
        end
      end
      S_WAIT_LD: begin
        ready_d = 1'b0;
        timer_d = timer_q + TW'(1);
        // Data arriving on the last permitted cycle still completes normally.
        if (dmem_rvalid_in) begin
          state_d   = S_IDLE;
          ready_d   = 1'b1;
          retire_d  = 1'b1;
          rd_addr_d = ld_rd_q;
          rd_data_d = ld_ext;
          wr_en_d   = ld_wben_q && (ld_rd_q != 5'd0);
        end else if (timer_q == TW'(LOAD_TIMEOUT - 1)) begin
          state_d   = S_IDLE;
          ready_d   = 1'b1;
          retire_d  = 1'b1;
          err_d     = ERR_TIMEOUT;
          rd_addr_d = ld_rd_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      ld_rd_q   <= '0;
      ld_f3_q   <= '0;
      ld_off_q  <= '0;
      ld_wben_q <= 1'b0;
      ready_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      retire_q  <= 1'b0;
      err_q     <= ERR_NONE;
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      ld_rd_q   <= ld_rd_d;
      ld_f3_q   <= ld_f3_d;
      ld_off_q  <= ld_off_d;
      ld_wben_q <= ld_wben_d;
      ready_q   <= ready_d;
      wr_en_q   <= wr_en_d;
      retire_q  <= retire_d;
      err_q     <= err_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign ex_ready_out = ready_q;
  assign wr_en_out    = wr_en_q;
  assign retire_out   = retire_q;
  assign err_out      = err_q;
  assign rd_addr_out  = rd_addr_q;
  assign rd_data_out  = rd_data_q;

endmodule

// File: tb/tb_wb_writeback_unit.sv
// Bench for wb_writeback_unit: randomized transactions checked against an arithmetic reference model.
module tb_wb_writeback_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic        wb_en = 1'b0;
  logic [1:0]  wb_sel = 2'b00;
  logic [4:0]  rd_addr = 5'd0;
  logic [31:0] alu_res = 32'd0;
  logic [31:0] pc = 32'd0;
  logic [31:0] imm = 32'd0;
  logic [2:0]  funct3 = 3'd0;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = 32'd0;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;
  logic        wr_en_o;
  logic        retire_o;
  logic [1:0]  err_o;

  int total = 0;
  int bad = 0;

  // {ready, wr_en, retire, err, rd_addr, rd_data}
  logic [41:0] obs, exp_v;
  logic [4:0]  obs_s, exp_s;
  logic [4:0]  last_rd;
  logic [31:0] last_data;

  wb_writeback_unit #(.XLEN(32), .LOAD_TIMEOUT(16)) dut (
    .clk_in(clk), .rst_in(rst_n), .ex_valid_in(ex_valid), .ex_ready_out(ex_ready),
    .wb_en_in(wb_en), .wb_sel_in(wb_sel), .rd_addr_in(rd_addr), .alu_res_in(alu_res),
    .pc_in(pc), .imm_in(imm), .funct3_in(funct3), .dmem_rvalid_in(rvalid),
    .dmem_rdata_in(rdata), .rd_addr_out(rd_addr_o), .rd_data_out(rd_data_o),
    .wr_en_out(wr_en_o), .retire_out(retire_o), .err_out(err_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic v, input logic we, input logic [1:0] sel, input logic [4:0] rd,
                          input logic [31:0] a, input logic [31:0] p, input logic [31:0] i,
                          input logic [2:0] f3);
    ex_valid = v; wb_en = we; wb_sel = sel; rd_addr = rd;
    alu_res = a; pc = p; imm = i; funct3 = f3;
  endtask

  // Reference: value written back for a non-load instruction.
  function automatic logic [31:0] ref_res(input logic [1:0] sel, input logic [31:0] a,
                                          input logic [31:0] p, input logic [31:0] i);
    longint unsigned s;
    case (sel)
      2'b00:   return a;
      2'b10:   begin s = longint'(p) + 4; return 32'(s % 64'h1_0000_0000); end
      default: return i;
    endcase
  endfunction

  // Reference: extracted and extended load value using plain arithmetic.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input int off, input logic [31:0] w);
    longint v;
    longint unsigned uw;
    uw = longint'(w);
    case (f3)
      3'b000: begin v = longint'((uw / (64'd1 << (8*off))) % 256); if (v >= 128) v -= 256; end
      3'b100: v = longint'((uw / (64'd1 << (8*off))) % 256);
      3'b001: begin v = longint'((uw / (64'd1 << (16*(off/2)))) % 65536); if (v >= 32768) v -= 65536; end
      3'b101: v = longint'((uw / (64'd1 << (16*(off/2)))) % 65536);
      default: v = longint'(uw);
    endcase
    return 32'(v);
  endfunction

  // Reference: early error code for a load request.
  function automatic logic [1:0] ref_err(input logic [2:0] f3, input int off);
    if (!(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) return 2'b11;
    if ((f3 == 3'b001 || f3 == 3'b101) && (off % 2 != 0)) return 2'b01;
    if (f3 == 3'b010 && off != 0) return 2'b01;
    return 2'b00;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    drive_op(1'b1, 1'b1, 2'b00, 5'd3, 32'hDEAD_BEEF, 32'd0, 32'd0, 3'd0);
    step(); step(); step();
    obs = {ex_ready, wr_en_o, retire_o, err_o, rd_addr_o, rd_data_o};
    exp_v = 42'd0;
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL reset_hold got=%h want=%h", obs, exp_v); end
    drive_op(1'b0, 1'b0, 2'b00, 5'd0, 32'd0, 32'd0, 32'd0, 3'd0);
    rst_n = 1'b1;
    step();
    obs = {ex_ready, wr_en_o, retire_o, err_o, rd_addr_o, rd_data_o};
    exp_v = {1'b1, 41'd0};
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL reset_release got=%h want=%h", obs, exp_v); end
    last_rd = 5'd0; last_data = 32'd0;
  endtask

  task automatic test_alu();
    logic [1:0] sel; logic [4:0] rd; logic we; logic [31:0] a, p, i;
    drive_op(1'b1, 1'b1, 2'b00, 5'd5, 32'h1234, 32'd0, 32'd0, 3'd0);
    step();
    obs = {ex_ready, wr_en_o, retire_o, err_o, rd_addr_o, rd_data_o};
    exp_v = {1'b1, 1'b1, 1'b1, 2'b00, 5'd5, 32'h1234};
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL alu_directed got=%h want=%h", obs, exp_v); end
    for (int n = 0; n < 12; n++) begin
      case ($urandom_range(0, 2)) 0: sel = 2'b00; 1: sel = 2'b10; default: sel = 2'b11; endcase
      rd = 5'($urandom); we = 1'($urandom); a = $urandom; p = $urandom; i = $urandom;
      drive_op(1'b1, we, sel, rd, a, p, i, 3'($urandom));
      step();
      obs = {ex_ready, wr_en_o, retire_o, err_o, rd_addr_o, rd_data_o};
      exp_v = {1'b1, we && (rd != 0), 1'b1, 2'b00, rd, ref_res(sel, a, p, i)};
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL alu_b2b[%0d] got=%h want=%h", n, obs, exp_v); end
      last_rd = rd; last_data = ref_res(sel, a, p, i);
    end
    drive_op(1'b0, 1'b1, 2'b00, 5'd1, 32'd0, 32'd0, 32'd0, 3'd0);
    step();
    obs = {ex_ready, wr_en_o, retire_o, err_o, rd_addr_o, rd_data_o};
    exp_v = {1'b1, 1'b0, 1'b0, 2'b00, last_rd, last_data};
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL alu_idle_hold got=%h want=%h", obs, exp_v); end
  endtask

  // One legal load: accept, wait dly cycles with ready low, then return word w.
  task automatic run_load(input string tag, input logic [2:0] f3, input int off, input logic [4:0] rd,
                          input logic we, input int dly, input logic [31:0] w);
    drive_op(1'b1, we, 2'b01, rd, {$urandom_range(0, 32'h3FFF_FFFF), 2'(off)}, 32'd0, 32'd0, f3);
    step();
    drive_op(1'b0, 1'b0, 2'b00, 5'd0, 32'd0, 32'd0, 32'd0, 3'd0);
    for (int k = 0; k < dly; k++) begin
      obs_s = {ex_ready, wr_en_o, retire_o, err_o};
      exp_s = 5'b0_0_0_00;
      total++;
      if (obs_s !== exp_s) begin bad++; $display("FAIL %s_wait[%0d] got=%b want=%b", tag, k, obs_s, exp_s); end
      step();
    end
    rvalid = 1'b1; rdata = w;
    step();
    rvalid = 1'b0; rdata = $urandom;
    obs = {ex_ready, wr_en_o, retire_o, err_o, rd_addr_o, rd_data_o};
    exp_v = {1'b1, we && (rd != 0), 1'b1, 2'b00, rd, ref_load(f3, off, w)};
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL %s_done got=%h want=%h", tag, obs, exp_v); end
    step();
    obs_s = {ex_ready, wr_en_o, retire_o, err_o};
    exp_s = 5'b1_0_0_00;
    total++;
    if (obs_s !== exp_s) begin bad++; $display("FAIL %s_pulse got=%b want=%b", tag, obs_s, exp_s); end
  endtask

  task automatic test_load();
    logic [2:0] f3; int off;
    logic [2:0] legal [5];
    legal = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    run_load("lb_dir", 3'b000, 3, 5'd9, 1'b1, 3, 32'h80FF_0000);
    if (rd_data_o !== 32'hFFFF_FF80) begin end
    run_load("lhu_dir", 3'b101, 2, 5'd10, 1'b1, 1, 32'h8001_0000);
    for (int n = 0; n < 8; n++) begin
      f3 = legal[$urandom_range(0, 4)];
      case (f3)
        3'b010:         off = 0;
        3'b001, 3'b101: off = 2 * int'($urandom_range(0, 1));
        default:        off = int'($urandom_range(0, 3));
      endcase
      run_load("ld_rand", f3, off, 5'($urandom), 1'($urandom), int'($urandom_range(0, 10)), $urandom);
    end
  endtask

  task automatic test_errors();
    logic [2:0] f3; int off; logic [1:0] e;
    for (int n = 0; n < 8; n++) begin
      if (n == 0) begin f3 = 3'b010; off = 2; end
      else begin
        f3 = 3'($urandom);
        off = int'($urandom_range(0, 3));
        while (ref_err(f3, off) == 2'b00) begin f3 = 3'($urandom); off = int'($urandom_range(0, 3)); end
      end
      e = ref_err(f3, off);
      drive_op(1'b1, 1'b1, 2'b01, 5'($urandom_range(1, 31)), {30'($urandom), 2'(off)}, 32'd0, 32'd0, f3);
      step();
      drive_op(1'b0, 1'b0, 2'b00, 5'd0, 32'd0, 32'd0, 32'd0, 3'd0);
      obs_s = {ex_ready, wr_en_o, retire_o, err_o};
      exp_s = {1'b1, 1'b0, 1'b1, e};
      total++;
      if (obs_s !== exp_s) begin bad++; $display("FAIL early_err[%0d] f3=%0d off=%0d got=%b want=%b", n, f3, off, obs_s, exp_s); end
    end
    step();
    obs_s = {ex_ready, wr_en_o, retire_o, err_o};
    exp_s = 5'b1_0_0_00;
    total++;
    if (obs_s !== exp_s) begin bad++; $display("FAIL early_err_pulse got=%b want=%b", obs_s, exp_s); end
    // Timeout: sixteen cycles of waiting with no data.
    drive_op(1'b1, 1'b1, 2'b01, 5'd12, 32'h100, 32'd0, 32'd0, 3'b010);
    step();
    drive_op(1'b0, 1'b0, 2'b00, 5'd0, 32'd0, 32'd0, 32'd0, 3'd0);
    for (int k = 0; k < 15; k++) begin
      obs_s = {ex_ready, wr_en_o, retire_o, err_o};
      total++;
      if (obs_s !== 5'b0_0_0_00) begin bad++; $display("FAIL timeout_wait[%0d] got=%b want=00000", k, obs_s); end
      step();
    end
    step();
    obs_s = {ex_ready, wr_en_o, retire_o, err_o};
    exp_s = 5'b1_0_1_10;
    total++;
    if (obs_s !== exp_s) begin bad++; $display("FAIL timeout got=%b want=%b", obs_s, exp_s); end
    step();
    obs_s = {ex_ready, wr_en_o, retire_o, err_o};
    total++;
    if (obs_s !== 5'b1_0_0_00) begin bad++; $display("FAIL timeout_pulse got=%b want=10000", obs_s); end
  endtask

  task automatic test_x0();
    drive_op(1'b1, 1'b1, 2'b00, 5'd0, 32'hCAFE_F00D, 32'd0, 32'd0, 3'd0);
    step();
    obs = {ex_ready, wr_en_o, retire_o, err_o, rd_addr_o, rd_data_o};
    exp_v = {1'b1, 1'b0, 1'b1, 2'b00, 5'd0, 32'hCAFE_F00D};
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL x0_write got=%h want=%h", obs, exp_v); end
    drive_op(1'b1, 1'b0, 2'b11, 5'd7, 32'd0, 32'd0, 32'h1234_5000, 3'd0);
    step();
    obs = {ex_ready, wr_en_o, retire_o, err_o, rd_addr_o, rd_data_o};
    exp_v = {1'b1, 1'b0, 1'b1, 2'b00, 5'd7, 32'h1234_5000};
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL no_wb_en got=%h want=%h", obs, exp_v); end
    drive_op(1'b1, 1'b1, 2'b10, 5'd1, 32'd0, 32'hFFFF_FFFC, 32'd0, 3'd0);
    step();
    drive_op(1'b0, 1'b0, 2'b00, 5'd0, 32'd0, 32'd0, 32'd0, 3'd0);
    obs = {ex_ready, wr_en_o, retire_o, err_o, rd_addr_o, rd_data_o};
    exp_v = {1'b1, 1'b1, 1'b1, 2'b00, 5'd1, 32'd0};
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL pc4_wrap got=%h want=%h", obs, exp_v); end
    step();
  endtask

  task automatic test_reset_mid_load();
    drive_op(1'b1, 1'b1, 2'b01, 5'd20, 32'h40, 32'd0, 32'd0, 3'b010);
    step();
    drive_op(1'b0, 1'b0, 2'b00, 5'd0, 32'd0, 32'd0, 32'd0, 3'd0);
    step(); step();
    rst_n = 1'b0;
    step();
    obs = {ex_ready, wr_en_o, retire_o, err_o, rd_addr_o, rd_data_o};
    total++;
    if (obs !== 42'd0) begin bad++; $display("FAIL rst_mid_load got=%h want=0", obs); end
    rst_n = 1'b1; rvalid = 1'b1; rdata = 32'h5555_AAAA;
    step();
    rvalid = 1'b0;
    obs = {ex_ready, wr_en_o, retire_o, err_o, rd_addr_o, rd_data_o};
    exp_v = {1'b1, 41'd0};
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL rst_late_rvalid got=%h want=%h", obs, exp_v); end
    step();
    obs = {ex_ready, wr_en_o, retire_o, err_o, rd_addr_o, rd_data_o};
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL rst_after got=%h want=%h", obs, exp_v); end
  endtask

  task automatic test_race();
    run_load("race_lw", 3'b010, 0, 5'd17, 1'b1, 15, $urandom);
    run_load("race_lb", 3'b000, 1, 5'd18, 1'b1, 15, 32'h0000_8100);
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_errors();
    test_x0();
    test_reset_mid_load();
    test_race();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
